// File: rtl/safe_lock_pkg.sv
// Shared types and constants for the safe lock code transmitter and unlock mechanism.
package safe_lock_pkg;

  localparam int SAFE_CODE_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    GAP   = 3'd2,
    RESP  = 3'd3,
    DONE  = 3'd4
  } tx_state_t;

  // Width of a down-counter that must hold max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/safe_code_tx.sv
// Serialises a code word MSB-first to the lock, then waits a bounded window for
// an unlock indication and reports one pass/fail pulse per transaction.
module safe_code_tx
  import safe_lock_pkg::*;
#(
  parameter int CODE_W     = SAFE_CODE_W,
  parameter int GAP_CYCLES = 0,
  parameter int RESP_WIN   = 2
) (
  input  logic              clk,
  input  logic              rst,
  // Handshake: a word transfers on any rising edge where code_valid && code_ready;
  // code_ready is high exactly while idle, and code_valid is ignored otherwise.
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code_data,
  output logic              code_ready,
  output logic              ser_val,
  output logic              ser_data,
  input  logic              resp_val,
  input  logic              resp_unlock,
  output logic              done,
  output logic              unlocked,
  output tx_state_t         dbg_state
);

  localparam int BW = cnt_w(CODE_W);
  localparam int GW = cnt_w(GAP_CYCLES);
  localparam int WW = cnt_w(RESP_WIN);

  tx_state_t         state_q;
  logic [CODE_W-1:0] sr_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [GW-1:0]     gap_cnt_q;
  logic [WW-1:0]     win_cnt_q;
  logic              result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      win_cnt_q <= '0;
      result_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (code_valid) begin
            sr_q      <= code_data;
            bit_cnt_q <= BW'(CODE_W);
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q      <= sr_q << 1;
          bit_cnt_q <= bit_cnt_q - 1'b1;
          if (bit_cnt_q == BW'(1)) begin
            win_cnt_q <= WW'(RESP_WIN);
            state_q   <= RESP;
          end else if (GAP_CYCLES > 0) begin
            gap_cnt_q <= GW'(GAP_CYCLES);
            state_q   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_q == GW'(1)) begin
            state_q <= SHIFT;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        RESP: begin
          // An unlock on the final window cycle still counts as a pass.
          if (resp_val && resp_unlock) begin
            result_q <= 1'b1;
            state_q  <= DONE;
          end else if (win_cnt_q == WW'(1)) begin
            result_q <= 1'b0;
            state_q  <= DONE;
          end else begin
            win_cnt_q <= win_cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign code_ready = (state_q == IDLE);
  assign ser_val    = (state_q == SHIFT);
  assign ser_data   = (state_q == SHIFT) & sr_q[CODE_W-1];
  assign done       = (state_q == DONE);
  assign unlocked   = (state_q == DONE) & result_q;
  assign dbg_state  = state_q;

endmodule
